uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl_pkg.sv | 28 ++
 rtl/uart_tx_ctrl_if.sv | 29 ++
 rtl/uart_tx_serializer.sv | 43 ++++
 rtl/uart_tx_ctrl.sv | 90 +++++++++
 tb/tb_uart_tx_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_ctrl_pkg.sv
`default_nettype none
// ============================================================
// uart_tx_ctrl_pkg : shared UART TX mux codes and state type
// Rev 1.0
// ============================================================
package uart_tx_ctrl_pkg;

   // Output-mux select codes, shared by the controller and the TX mux
   localparam logic [2:0] MUX_IDLE   = 3'b000;
   localparam logic [2:0] MUX_START  = 3'b001;
   localparam logic [2:0] MUX_DATA   = 3'b010;
   localparam logic [2:0] MUX_PARITY = 3'b011;
   localparam logic [2:0] MUX_STOP   = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE   = MUX_IDLE,
      ST_START  = MUX_START,
      ST_DATA   = MUX_DATA,
      ST_PARITY = MUX_PARITY,
      ST_STOP   = MUX_STOP
   } tx_state_t;

   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_ctrl_if.sv
`default_nettype none
// ============================================================
// uart_tx_ctrl_if : request and status bundle of the TX controller
// Rev 1.0
// ============================================================
interface uart_tx_ctrl_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int MUX_SEL_WIDTH = 3
);
   logic [DATA_WIDTH-1:0]    P_DATA;
   logic                     Data_Valid;
   logic                     PAR_EN;
   logic                     PAR_TYP;
   logic [MUX_SEL_WIDTH-1:0] mux_sel;
   logic                     ser_data;
   logic                     par_bit;
   logic                     busy;

   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
      input  mux_sel, ser_data, par_bit, busy
   );

   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
      output mux_sel, ser_data, par_bit, busy
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================
// uart_tx_serializer : LSB-first shift register with bit counter
// Rev 1.0
// ============================================================
module uart_tx_serializer
   import uart_tx_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  wire logic                  CLK,
   input  wire logic                  RST,
   input  wire logic                  load,
   input  wire logic                  enable,
   input  wire logic [DATA_WIDTH-1:0] data,
   output      logic                  ser_bit,
   output      logic                  done
);
   localparam int CNT_W = cnt_width(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] shreg;
   logic [CNT_W-1:0]      bit_cnt;

   // Counter holds on the last bit so it never wraps inside a frame
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         shreg   <= data;
         bit_cnt <= '0;
      end else if (enable && !done) begin
         shreg   <= shreg >> 1;
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   assign ser_bit = shreg[0];
   assign done    = (bit_cnt == LAST_BIT);

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================
// uart_tx_ctrl : UART transmit frame FSM driving the TX output mux
// Rev 1.0
// ============================================================
module uart_tx_ctrl
   import uart_tx_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int MUX_SEL_WIDTH = 3
) (
   input wire logic      CLK,
   input wire logic      RST,
   uart_tx_ctrl_if.slave bus
);
   tx_state_t state;
   tx_state_t next_state;
   logic      load;
   logic      shift_en;
   logic      done;
   logic      ser_bit;
   logic      par_en_q;
   logic      par_bit_q;
   logic      busy_q;

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_serializer (
      .CLK     (CLK),
      .RST     (RST),
      .load    (load),
      .enable  (shift_en),
      .data    (bus.P_DATA),
      .ser_bit (ser_bit),
      .done    (done)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= ST_IDLE;
         busy_q    <= 1'b0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         state  <= next_state;
         busy_q <= (next_state != ST_IDLE);
         if (load) begin
            par_en_q  <= bus.PAR_EN;
            par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
         end
      end
   end

   // Data_Valid is only honoured in IDLE and STOP; STOP accepts back-to-back
   always_comb begin
      next_state = state;
      load       = 1'b0;
      shift_en   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.Data_Valid) begin
               load       = 1'b1;
               next_state = ST_START;
            end
         end
         ST_START:  next_state = ST_DATA;
         ST_DATA: begin
            shift_en = 1'b1;
            if (done) next_state = par_en_q ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: next_state = ST_STOP;
         ST_STOP: begin
            if (bus.Data_Valid) begin
               load       = 1'b1;
               next_state = ST_START;
            end else begin
               next_state = ST_IDLE;
            end
         end
         default:   next_state = ST_IDLE;
      endcase
   end

   assign bus.mux_sel  = MUX_SEL_WIDTH'(state);
   assign bus.busy     = busy_q;
   assign bus.par_bit  = par_bit_q;
   assign bus.ser_data = (state == ST_DATA) && ser_bit;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================
// tb_uart_tx_ctrl : directed self-checking bench for uart_tx_ctrl
// Rev 1.0
// ============================================================
module tb_uart_tx_ctrl;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   uart_tx_ctrl_if #(.DATA_WIDTH(8), .MUX_SEL_WIDTH(3)) bus ();

   uart_tx_ctrl #(
      .DATA_WIDTH    (8),
      .MUX_SEL_WIDTH (3)
   ) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Frame cycle c counts from 0 at START
   function automatic logic [2:0] exp_mux(input int c, input bit pe);
      if (c == 0) return 3'b001;
      if (c <= 8) return 3'b010;
      if (pe && c == 9) return 3'b011;
      return 3'b100;
   endfunction

   function automatic logic exp_ser(input int c, input logic [7:0] d);
      if (c >= 1 && c <= 8) return d[c-1];
      return 1'b0;
   endfunction

   task automatic test_reset();
      checks++;
      if ({bus.mux_sel, bus.busy, bus.ser_data, bus.par_bit} !== 6'b000000) begin
         errors++;
         $display("FAIL reset_state: got mux=%b busy=%b ser=%b par=%b, want 000 0 0 0",
                  bus.mux_sel, bus.busy, bus.ser_data, bus.par_bit);
      end
   endtask

   task automatic test_frame(input logic [7:0] d, input bit pe, input bit pt,
                             input logic ep, input string name);
      int len;
      len = pe ? 11 : 10;
      bus.P_DATA = d; bus.PAR_EN = pe; bus.PAR_TYP = pt; bus.Data_Valid = 1'b1;
      step();
      bus.Data_Valid = 1'b0;
      for (int c = 0; c < len; c++) begin
         if (c > 0) step();
         checks++;
         if ({bus.mux_sel, bus.busy, bus.ser_data, bus.par_bit} !==
             {exp_mux(c, pe), 1'b1, exp_ser(c, d), ep}) begin
            errors++;
            $display("FAIL %s cyc%0d: got mux=%b busy=%b ser=%b par=%b, want mux=%b busy=1 ser=%b par=%b",
                     name, c, bus.mux_sel, bus.busy, bus.ser_data, bus.par_bit,
                     exp_mux(c, pe), exp_ser(c, d), ep);
         end
      end
      step();
      checks++;
      if ({bus.mux_sel, bus.busy, bus.ser_data} !== 5'b00000) begin
         errors++;
         $display("FAIL %s idle_after: got mux=%b busy=%b ser=%b, want 000 0 0",
                  name, bus.mux_sel, bus.busy, bus.ser_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d2;
      d2 = 8'h3C;
      bus.P_DATA = 8'hA5; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
      step();
      bus.Data_Valid = 1'b0;
      for (int c = 1; c <= 9; c++) step();
      checks++;
      if ({bus.mux_sel, bus.busy} !== 4'b1001) begin
         errors++;
         $display("FAIL b2b_stop: got mux=%b busy=%b, want 100 1", bus.mux_sel, bus.busy);
      end
      bus.P_DATA = d2; bus.Data_Valid = 1'b1;
      step();
      bus.Data_Valid = 1'b0;
      bus.P_DATA = 8'h00;
      checks++;
      if ({bus.mux_sel, bus.busy} !== 4'b0011) begin
         errors++;
         $display("FAIL b2b_start: got mux=%b busy=%b, want 001 1", bus.mux_sel, bus.busy);
      end
      for (int c = 1; c <= 9; c++) begin
         step();
         checks++;
         if ({bus.mux_sel, bus.busy, bus.ser_data} !== {exp_mux(c, 1'b0), 1'b1, exp_ser(c, d2)}) begin
            errors++;
            $display("FAIL b2b_frame2 cyc%0d: got mux=%b busy=%b ser=%b, want mux=%b busy=1 ser=%b",
                     c, bus.mux_sel, bus.busy, bus.ser_data, exp_mux(c, 1'b0), exp_ser(c, d2));
         end
      end
      step();
      checks++;
      if ({bus.mux_sel, bus.busy} !== 4'b0000) begin
         errors++;
         $display("FAIL b2b_idle: got mux=%b busy=%b, want 000 0", bus.mux_sel, bus.busy);
      end
   endtask

   // Inputs disturbed mid-frame: Data_Valid in DATA plus new P_DATA/PAR_EN/PAR_TYP
   task automatic test_ignore_inputs(input logic [7:0] d, input int hit, input string name);
      logic ep;
      ep = ^d;
      bus.P_DATA = d; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
      step();
      bus.Data_Valid = 1'b0;
      for (int c = 0; c < 11; c++) begin
         if (c > 0) step();
         if (c == hit) begin
            bus.P_DATA = 8'hFF; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b1; bus.Data_Valid = 1'b1;
         end else begin
            bus.Data_Valid = 1'b0;
         end
         checks++;
         if ({bus.mux_sel, bus.busy, bus.ser_data, bus.par_bit} !==
             {exp_mux(c, 1'b1), 1'b1, exp_ser(c, d), ep}) begin
            errors++;
            $display("FAIL %s cyc%0d: got mux=%b busy=%b ser=%b par=%b, want mux=%b busy=1 ser=%b par=%b",
                     name, c, bus.mux_sel, bus.busy, bus.ser_data, bus.par_bit,
                     exp_mux(c, 1'b1), exp_ser(c, d), ep);
         end
      end
      bus.Data_Valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step();
         checks++;
         if ({bus.mux_sel, bus.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL %s idle%0d: got mux=%b busy=%b, want 000 0", name, k, bus.mux_sel, bus.busy);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      bus.P_DATA = 8'h3C; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1; bus.Data_Valid = 1'b1;
      step();
      bus.Data_Valid = 1'b0;
      for (int c = 1; c <= 5; c++) step();
      checks++;
      if ({bus.mux_sel, bus.ser_data, bus.par_bit} !== 5'b01011) begin
         errors++;
         $display("FAIL rst_pre: got mux=%b ser=%b par=%b, want 010 1 1",
                  bus.mux_sel, bus.ser_data, bus.par_bit);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.mux_sel, bus.busy, bus.ser_data, bus.par_bit} !== 6'b000000) begin
         errors++;
         $display("FAIL rst_async: got mux=%b busy=%b ser=%b par=%b, want 000 0 0 0",
                  bus.mux_sel, bus.busy, bus.ser_data, bus.par_bit);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if ({bus.mux_sel, bus.busy, bus.ser_data} !== 5'b00000) begin
            errors++;
            $display("FAIL rst_hold_idle%0d: got mux=%b busy=%b ser=%b, want 000 0 0",
                     k, bus.mux_sel, bus.busy, bus.ser_data);
         end
      end
      bus.P_DATA = 8'h01; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
      step();
      bus.Data_Valid = 1'b0;
      checks++;
      if ({bus.mux_sel, bus.busy} !== 4'b0011) begin
         errors++;
         $display("FAIL rst_restart: got mux=%b busy=%b, want 001 1", bus.mux_sel, bus.busy);
      end
      step();
      checks++;
      if ({bus.mux_sel, bus.ser_data} !== 4'b0101) begin
         errors++;
         $display("FAIL rst_restart_bit0: got mux=%b ser=%b, want 010 1", bus.mux_sel, bus.ser_data);
      end
      for (int k = 0; k < 12; k++) step();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      bus.P_DATA = '0; bus.Data_Valid = 1'b0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      test_frame(8'hA5, 1'b0, 1'b0, 1'b0, "a5_nopar");
      test_frame(8'hA5, 1'b1, 1'b0, 1'b0, "a5_even");
      test_frame(8'hA5, 1'b1, 1'b1, 1'b1, "a5_odd");
      test_frame(8'h07, 1'b1, 1'b0, 1'b1, "07_even");
      test_back_to_back();
      test_ignore_inputs(8'hA5, 4, "dv_in_data");
      test_ignore_inputs(8'h5A, 0, "pdata_change");
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
